// File: rtl/data_mem_ctrl.sv
// Data memory controller for an RV32I core.
// Accepts one load/store at a time, performs byte/half/word access on a
// word-organised array, and reports completion with a one-cycle ready pulse
// a fixed LATENCY edges after acceptance. Misaligned or illegal accesses
// complete with err=1, never touch the array and return rdata=0.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE       = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [SIZE-1:0]       wdata,
    output logic [SIZE-1:0]       rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  busy
);

    localparam int DEPTH        = 1 << (ADDR_WIDTH - 2);
    localparam int IDX_W        = ADDR_WIDTH - 2;
    localparam int WAIT_INIT_I  = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [2:0] WAIT_INIT = WAIT_INIT_I[2:0];
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (SIZE != 32) begin : g_bad_size
            $error("data_mem_ctrl: SIZE must be 32");
        end
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("data_mem_ctrl: LATENCY must be in 1..8");
        end
    endgenerate

    // Access-fault decode: illegal funct3 for the direction, or an address
    // not aligned to the access size (funct3[1:0] encodes the size).
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (is_store) begin
            bad = (f3 > 3'd2);
        end else begin
            bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        case (f3[1:0])
            2'b01:   if (lane[0]) bad = 1'b1;
            2'b10:   if (lane != 2'b00) bad = 1'b1;
            default: ;
        endcase
        return bad;
    endfunction

    // Select and extend the addressed byte/half from a little-endian word.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Merge LSB-aligned store data into the addressed byte lanes only.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000: res[{lane, 3'b000} +: 8] = wd[7:0];
            3'b001: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            3'b010:  res = wd;
            default: ;
        endcase
        return res;
    endfunction

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [31:0]           mem [DEPTH];

    // Request held for the wait phase; store data is consumed on the
    // acceptance edge itself, so it needs no holding register.
    logic                  we_p0;
    logic [2:0]            funct3_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;

    logic                  cur_we;
    logic [2:0]            cur_funct3;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [IDX_W-1:0]      cur_idx;
    logic [31:0]           cur_word;
    logic                  cur_err;
    logic                  accept;
    logic                  enter_done;

    // Live inputs while idle (acceptance / single-cycle completion),
    // captured request otherwise.
    always_comb begin
        cur_we     = we_p0;
        cur_funct3 = funct3_p0;
        cur_addr   = addr_p0;
        if (state == S_IDLE) begin
            cur_we     = we;
            cur_funct3 = funct3;
            cur_addr   = addr;
        end
        cur_idx    = cur_addr[ADDR_WIDTH-1:2];
        cur_word   = mem[cur_idx];
        cur_err    = access_err(cur_we, cur_funct3, cur_addr[1:0]);
        accept     = RESET_N && (state == S_IDLE) && req;
        enter_done = ((state == S_IDLE) && req && SINGLE_CYCLE) ||
                     ((state == S_WAIT) && (cnt == 3'd0));
    end

    assign busy = (state != S_IDLE);

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if ((state == S_IDLE) && req) begin
            we_p0     <= we;
            funct3_p0 <= funct3;
            addr_p0   <= addr;
        end
    end

    // Stores commit on the acceptance edge; faulting stores never write.
    always_ff @(posedge CLK) begin
        if (accept && cur_we && !cur_err) begin
            mem[cur_idx] <= store_merge(cur_word, wdata, cur_funct3, cur_addr[1:0]);
        end
    end

    // Control FSM, wait counter and registered completion outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= enter_done;
            err   <= enter_done && cur_err;
            if (enter_done && !cur_we) begin
                rdata <= cur_err ? 32'd0 : load_extract(cur_word, cur_funct3, cur_addr[1:0]);
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= SINGLE_CYCLE ? S_DONE : S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) state <= S_DONE;
                    else             cnt   <= cnt - 3'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance at LATENCY=1 and one at LATENCY=4,
// a table of directed accesses, reset corner cases and random traffic
// compared against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int AW   = 10;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          rst_n_s [2];
    logic          req_s   [2];
    logic          we_s    [2];
    logic [2:0]    f3_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [31:0]   wdata_s [2];
    logic [31:0]   rdata_s [2];
    logic          ready_s [2];
    logic          err_s   [2];
    logic          busy_s  [2];

    data_mem_ctrl #(.ADDR_WIDTH(AW), .SIZE(32), .LATENCY(LAT0)) u_dut0 (
        .CLK(CLK), .RESET_N(rst_n_s[0]), .req(req_s[0]), .we(we_s[0]),
        .funct3(f3_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0])
    );

    data_mem_ctrl #(.ADDR_WIDTH(AW), .SIZE(32), .LATENCY(LAT1)) u_dut1 (
        .CLK(CLK), .RESET_N(rst_n_s[1]), .req(req_s[1]), .we(we_s[1]),
        .funct3(f3_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: byte-addressed memory and last load result per DUT.
    bit [7:0]  mb  [2][1024];
    bit [31:0] mrd [2];

    typedef struct {
        bit        w;
        bit [2:0]  f3;
        int        a;
        bit [31:0] wd;
        bit [31:0] exp_rd;
        bit        exp_err;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_apply(input int d, input bit w, input bit [2:0] f, input int a,
                               input bit [31:0] wd, output bit e, output bit [31:0] rd);
        int     nb;
        longint v;
        if (w) e = (f > 3'd2);
        else   e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
        nb = 1 << (int'(f) % 4);
        if (!e && (a % nb) != 0) e = 1'b1;
        if (w) begin
            if (!e) for (int i = 0; i < nb; i++) mb[d][a + i] = wd[8*i +: 8];
            rd = mrd[d];
        end else begin
            v = 0;
            if (!e) begin
                for (int i = 0; i < nb; i++) v += longint'(mb[d][a + i]) << (8 * i);
                if (f < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                    v -= longint'(1) << (8 * nb);
            end
            rd = v[31:0];
            mrd[d] = rd;
        end
    endtask

    task automatic scramble(input int d, input bit noise);
        we_s[d]    = 1'($urandom_range(0, 1));
        f3_s[d]    = 3'($urandom_range(0, 7));
        addr_s[d]  = 10'($urandom_range(0, 1023));
        wdata_s[d] = $urandom;
        req_s[d]   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One access: returns edges to ready, busy samples, and rdata/err at ready.
    task automatic do_txn(input int d, input bit w, input bit [2:0] f, input int a,
                          input bit [31:0] wd, input bit noise,
                          output int lat, output int bcnt,
                          output logic [31:0] g_rd, output logic g_err);
        @(negedge CLK);
        req_s[d] = 1'b1; we_s[d] = w; f3_s[d] = f; addr_s[d] = a[AW-1:0]; wdata_s[d] = wd;
        @(posedge CLK); #1;
        lat = 1; bcnt = 0;
        g_rd = 'x; g_err = 1'bx;
        req_s[d] = 1'b0;
        while (1) begin
            if (busy_s[d]) bcnt++;
            if (ready_s[d] || lat >= 20) break;
            scramble(d, noise);
            @(posedge CLK); #1;
            lat++;
        end
        g_rd  = rdata_s[d];
        g_err = err_s[d];
        scramble(d, noise);
        @(posedge CLK); #1;
        req_s[d] = 1'b0;
        check($sformatf("ready_pulse_d%0d", d), 32'(ready_s[d]), 32'd0);
        check($sformatf("busy_after_d%0d", d), 32'(busy_s[d]), 32'd0);
    endtask

    task automatic run_model(input int d, input bit w, input bit [2:0] f, input int a,
                             input bit [31:0] wd, input bit noise);
        bit          e;
        bit [31:0]   rd;
        int          lat, bcnt;
        logic [31:0] g_rd;
        logic        g_err;
        model_apply(d, w, f, a, wd, e, rd);
        do_txn(d, w, f, a, wd, noise, lat, bcnt, g_rd, g_err);
        check($sformatf("lat_d%0d a=%h f=%0d w=%0d", d, a, f, w), 32'(lat), 32'(lat_of(d)));
        check($sformatf("busy_cycles_d%0d", d), 32'(bcnt), 32'(lat_of(d)));
        check($sformatf("err_d%0d a=%h f=%0d w=%0d", d, a, f, w), 32'(g_err), 32'(e));
        check($sformatf("rdata_d%0d a=%h f=%0d w=%0d", d, a, f, w), g_rd, rd);
        check($sformatf("rdata_hold_d%0d", d), rdata_s[d], rd);
    endtask

    initial begin
        bit          e;
        bit [31:0]   rd;
        int          lat, bcnt, a, rcnt;
        logic [31:0] g_rd;
        logic        g_err;
        bit          w;
        bit [2:0]    f;

        tbl[0]  = '{1'b1, 3'b010, 'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 3'b010, 'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 'h013, 32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3]  = '{1'b0, 3'b100, 'h013, 32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[5]  = '{1'b0, 3'b101, 'h010, 32'h0,        32'h0000BEEF, 1'b0};
        tbl[6]  = '{1'b1, 3'b000, 'h011, 32'hFFFFFF55, 32'h0000BEEF, 1'b0};
        tbl[7]  = '{1'b0, 3'b010, 'h010, 32'h0,        32'hDEAD55EF, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 'h012, 32'h0,        32'h00000000, 1'b1};
        tbl[9]  = '{1'b1, 3'b010, 'h000, 32'h12345678, 32'h00000000, 1'b0};
        tbl[10] = '{1'b1, 3'b001, 'h001, 32'h0000AAAA, 32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 3'b010, 'h000, 32'h0,        32'h12345678, 1'b0};
        tbl[12] = '{1'b0, 3'b011, 'h000, 32'h0,        32'h00000000, 1'b1};
        tbl[13] = '{1'b1, 3'b001, 'h002, 32'h1234CAFE, 32'h00000000, 1'b0};
        tbl[14] = '{1'b0, 3'b010, 'h000, 32'h0,        32'hCAFE5678, 1'b0};
        tbl[15] = '{1'b1, 3'b011, 'h004, 32'h77777777, 32'hCAFE5678, 1'b1};
        tbl[16] = '{1'b0, 3'b101, 'h002, 32'h0,        32'h0000CAFE, 1'b0};

        // Reset with req held high: nothing may be accepted.
        for (int d = 0; d < 2; d++) begin
            rst_n_s[d] = 1'b0; req_s[d] = 1'b1; we_s[d] = 1'b0; f3_s[d] = 3'b010;
            addr_s[d] = '0; wdata_s[d] = '0; mrd[d] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready_d%0d", d), 32'(ready_s[d]), 32'd0);
            check($sformatf("rst_err_d%0d", d),   32'(err_s[d]),   32'd0);
            check($sformatf("rst_busy_d%0d", d),  32'(busy_s[d]),  32'd0);
            check($sformatf("rst_rdata_d%0d", d), rdata_s[d],      32'd0);
            req_s[d] = 1'b0;
            rst_n_s[d] = 1'b1;
        end
        @(posedge CLK); #1;
        check("idle_after_rst_d0", 32'(busy_s[0]), 32'd0);

        // Give every word a known value so random loads are fully predictable.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                run_model(d, 1'b1, 3'b010, i * 4, $urandom, 1'b0);

        // Directed table on the single-cycle instance.
        for (int i = 0; i < 17; i++) begin
            model_apply(0, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, e, rd);
            do_txn(0, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b0, lat, bcnt, g_rd, g_err);
            check($sformatf("tbl%0d_lat", i),   32'(lat),   32'(LAT0));
            check($sformatf("tbl%0d_err", i),   32'(g_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_rdata", i), g_rd,       tbl[i].exp_rd);
        end

        // LATENCY=4 with req noise while busy.
        run_model(1, 1'b1, 3'b010, 'h020, 32'hCAFEF00D, 1'b1);
        run_model(1, 1'b0, 3'b010, 'h020, 32'h0, 1'b1);
        run_model(1, 1'b0, 3'b000, 'h023, 32'h0, 1'b1);

        // Store committed at acceptance survives a reset on the next edge.
        @(negedge CLK);
        req_s[1] = 1'b1; we_s[1] = 1'b1; f3_s[1] = 3'b010; addr_s[1] = 10'h040; wdata_s[1] = 32'hA5A51234;
        model_apply(1, 1'b1, 3'b010, 'h040, 32'hA5A51234, e, rd);
        @(posedge CLK); #1;
        rst_n_s[1] = 1'b0; req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 10'h040; wdata_s[1] = 32'h0;
        @(posedge CLK); #1;
        check("st_rst_ready", 32'(ready_s[1]), 32'd0);
        check("st_rst_busy",  32'(busy_s[1]),  32'd0);
        rst_n_s[1] = 1'b1; req_s[1] = 1'b0;
        mrd[1] = '0;
        run_model(1, 1'b0, 3'b010, 'h040, 32'h0, 1'b0);

        // Load aborted by reset two edges after acceptance.
        @(negedge CLK);
        req_s[1] = 1'b1; we_s[1] = 1'b0; f3_s[1] = 3'b010; addr_s[1] = 10'h040;
        @(posedge CLK); #1;
        req_s[1] = 1'b0;
        @(posedge CLK); #1;
        rst_n_s[1] = 1'b0;
        @(posedge CLK); #1;
        check("ld_rst_ready", 32'(ready_s[1]), 32'd0);
        check("ld_rst_busy",  32'(busy_s[1]),  32'd0);
        check("ld_rst_rdata", rdata_s[1],      32'd0);
        rst_n_s[1] = 1'b1;
        mrd[1] = '0;
        rcnt = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (ready_s[1]) rcnt++;
        end
        check("ld_rst_no_ready", 32'(rcnt), 32'd0);
        run_model(1, 1'b0, 3'b010, 'h040, 32'h0, 1'b0);

        // Random traffic against the model on both instances.
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < 2; d++) begin
                w = 1'($urandom_range(0, 1));
                f = 3'($urandom_range(0, 7));
                a = int'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0) a = a & ~3;
                run_model(d, w, f, a, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, byte-address width; storage depth 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 The block SHALL have parameter SIZE, default 32, data width; only 32 is legal.
REQ-003 The block SHALL have parameter LATENCY, default 1, legal 1..8: clock edges from request acceptance to ready.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port req, input, 1, access request, sampled only in IDLE.
REQ-007 The block SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port funct3, input, 3, RV32I access type.
REQ-009 The block SHALL have port addr, input, ADDR_WIDTH, byte address.
REQ-010 The block SHALL have port wdata, input, SIZE, store data, LSB-aligned.
REQ-011 The block SHALL have port rdata, output, SIZE, load result, registered.
REQ-012 The block SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1, misaligned or illegal access; valid only with ready.
REQ-014 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE. IDLE->WAIT on req=1, or IDLE->DONE when req=1 and LATENCY=1. WAIT->DONE when the wait counter expires. DONE->IDLE unconditionally.
REQ-016 On acceptance the block SHALL capture we, funct3, addr and wdata; input changes after acceptance SHALL have no effect.
REQ-017 ready SHALL be high exactly LATENCY cycles after the acceptance edge, for one cycle, in DONE only.
REQ-018 req while busy=1, including during the DONE cycle, SHALL be ignored and not queued.
REQ-019 Loads SHALL decode funct3 as: 000 LB sign-extend; 001 LH sign-extend; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend.
REQ-020 Stores SHALL decode funct3 as: 000 SB, 001 SH, 010 SW. A store SHALL modify only the addressed byte lanes (lane = addr[1:0]).
REQ-021 Byte/half selection SHALL be little-endian: byte n of a word occupies bits 8n+7:8n.
REQ-022 A store SHALL commit to the array on the acceptance edge. A load issued after that store completes SHALL return the new data.
REQ-023 Misalignment SHALL be defined as: half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-024 Illegal funct3 SHALL be defined as: load 011/110/111, or store other than 000/001/010.
REQ-025 On misaligned or illegal access: no array write, rdata=0, err=1 together with ready, same LATENCY timing.
REQ-026 rdata SHALL update only in the DONE cycle of a load and SHALL hold its value until the next load completes. Stores SHALL leave rdata unchanged.
REQ-027 Address wrap SHALL NOT occur; the full ADDR_WIDTH is decoded with no aliasing beyond the word index.

Reset
REQ-028 While RESET_N=0 at a clock edge: state=IDLE, counter=0, ready=0, err=0, busy=0, rdata=0.
REQ-029 Reset mid-operation SHALL abort the access with no ready pulse. A store already committed at acceptance SHALL remain written.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 req SHALL be ignored on any edge where RESET_N=0.

Verification
REQ-032 LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> ready 1 cycle after each acceptance; rdata=0xDEADBEEF, err=0.
REQ-033 After REQ-032: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-034 SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF, proving the other lanes are untouched.
REQ-035 LW @0x12 and SH @0x01 -> err=1 with ready, rdata=0, memory unchanged; load funct3=011 -> err=1.
REQ-036 LATENCY=4: ready exactly 4 edges after acceptance; busy high for 4 cycles; a req pulsed while busy produces no second ready.
REQ-037 LATENCY=4: assert RESET_N=0 two cycles after accepting a LW -> no ready, busy=0, rdata=0 on the next edge; a following LW completes normally.
